// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word width, ALU opcodes, request entry layout and driver FSM states.
package cpu_types_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned OP_W      = 4;
  localparam int unsigned TAG_W     = 4;
  localparam int unsigned OVF_CNT_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [OP_W-1:0] {
    ALU_SLL  = 4'h0,
    ALU_SRL  = 4'h1,
    ALU_ADD  = 4'h2,
    ALU_SUB  = 4'h3,
    ALU_AND  = 4'h4,
    ALU_OR   = 4'h5,
    ALU_XOR  = 4'h6,
    ALU_NOR  = 4'h7,
    ALU_SLT  = 4'h8,
    ALU_SLTU = 4'h9
  } aluop_t;

  typedef struct packed {
    word_t              opa;
    word_t              opb;
    aluop_t             op;
    logic [TAG_W-1:0]   tag;
  } alu_req_t;

  typedef enum logic [1:0] {
    DRV_IDLE,
    DRV_DRIVE,
    DRV_RESP
  } drv_state_t;

endpackage

// File: rtl/alu_if.sv
// Connection to a combinational ALU; the tb modport is the side that drives operands.
interface alu_if;
  import cpu_types_pkg::*;

  word_t  PortA;
  word_t  PortB;
  aluop_t ALUOP;
  word_t  OutputPort;
  logic   Negative;
  logic   Overflow;
  logic   Zero;

  modport tb  (output PortA, PortB, ALUOP, input Negative, OutputPort, Overflow, Zero);
  modport alu (input PortA, PortB, ALUOP, output Negative, OutputPort, Overflow, Zero);
endinterface

// File: rtl/alu_req_fifo.sv
// Request queue; full/empty decode the registered count so a full queue refuses a push
// even when a pop happens on the same edge.
module alu_req_fifo
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  alu_req_t wdata,
  output alu_req_t rdata_c,
  output logic     full_c,
  output logic     empty_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  alu_req_t         mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == '0);
  assign push_ok = push && !full_c;
  assign pop_ok  = pop && !empty_c;
  assign rdata_c = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PTR_W'(1);
      if (pop_ok)  rptr <= rptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/alu_driver.sv
// Queues ALU requests, presents each to an external combinational ALU for one cycle,
// and returns the captured result with its tag over a valid/ready response port.
module alu_driver
  import cpu_types_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WORD_W-1:0]    req_opa,
  input  logic [WORD_W-1:0]    req_opb,
  input  logic [OP_W-1:0]      req_op,
  input  logic [TAG_W-1:0]     req_tag,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [WORD_W-1:0]    resp_result,
  output logic                 resp_neg,
  output logic                 resp_ovf,
  output logic                 resp_zero,
  output logic [TAG_W-1:0]     resp_tag,
  alu_if.tb                    aluif,
  output logic                 busy,
  output logic [OVF_CNT_W-1:0] ovf_count
);

  drv_state_t state;
  drv_state_t state_next;
  alu_req_t   req_entry;
  alu_req_t   head;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;

  assign req_entry = '{opa: req_opa, opb: req_opb, op: aluop_t'(req_op), tag: req_tag};
  assign req_ready = !full;
  assign push      = req_valid && !full;

  alu_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .push    (push),
    .pop     (pop),
    .wdata   (req_entry),
    .rdata_c (head),
    .full_c  (full),
    .empty_c (empty)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= DRV_IDLE;
    else     state <= state_next;
  end

  // ALU ports are only non-zero while the head entry is being evaluated.
  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    aluif.PortA = '0;
    aluif.PortB = '0;
    aluif.ALUOP = aluop_t'(OP_W'(0));
    case (state)
      DRV_IDLE: begin
        if (!empty) state_next = DRV_DRIVE;
      end
      DRV_DRIVE: begin
        aluif.PortA = head.opa;
        aluif.PortB = head.opb;
        aluif.ALUOP = head.op;
        pop         = 1'b1;
        state_next  = DRV_RESP;
      end
      DRV_RESP: begin
        // A push on the handshake edge counts as pending work.
        if (resp_ready) state_next = (!empty || push) ? DRV_DRIVE : DRV_IDLE;
      end
      default: state_next = DRV_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      resp_result <= '0;
      resp_neg    <= 1'b0;
      resp_ovf    <= 1'b0;
      resp_zero   <= 1'b0;
      resp_tag    <= '0;
      ovf_count   <= '0;
    end else if (state == DRV_DRIVE) begin
      resp_result <= aluif.OutputPort;
      resp_neg    <= aluif.Negative;
      resp_ovf    <= aluif.Overflow;
      resp_zero   <= aluif.Zero;
      resp_tag    <= head.tag;
      if (aluif.Overflow && (ovf_count != '1)) ovf_count <= ovf_count + OVF_CNT_W'(1);
    end
  end

  assign resp_valid = (state == DRV_RESP);
  assign busy       = (state != DRV_IDLE) || !empty;

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver with a small combinational ALU on the interface.
module tb_alu_driver;
  import cpu_types_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  word_t       req_opa;
  word_t       req_opb;
  logic [3:0]  req_op;
  logic [3:0]  req_tag;
  logic        resp_valid;
  logic        resp_ready;
  word_t       resp_result;
  logic        resp_neg;
  logic        resp_ovf;
  logic        resp_zero;
  logic [3:0]  resp_tag;
  logic        busy;
  logic [15:0] ovf_count;

  int n_checks = 0;
  int n_fail   = 0;

  alu_if aluif_i ();

  alu_driver #(.FIFO_DEPTH(4)) dut (
    .CLK         (clk),
    .RST         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_opa     (req_opa),
    .req_opb     (req_opb),
    .req_op      (req_op),
    .req_tag     (req_tag),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_neg    (resp_neg),
    .resp_ovf    (resp_ovf),
    .resp_zero   (resp_zero),
    .resp_tag    (resp_tag),
    .aluif       (aluif_i),
    .busy        (busy),
    .ovf_count   (ovf_count)
  );

  // External combinational ALU
  word_t alu_r;
  logic  alu_v;
  always_comb begin
    alu_r = '0;
    alu_v = 1'b0;
    case (aluif_i.ALUOP)
      ALU_ADD: begin
        alu_r = aluif_i.PortA + aluif_i.PortB;
        alu_v = (aluif_i.PortA[31] == aluif_i.PortB[31]) && (alu_r[31] != aluif_i.PortA[31]);
      end
      ALU_SUB: begin
        alu_r = aluif_i.PortA - aluif_i.PortB;
        alu_v = (aluif_i.PortA[31] != aluif_i.PortB[31]) && (alu_r[31] != aluif_i.PortA[31]);
      end
      ALU_AND: alu_r = aluif_i.PortA & aluif_i.PortB;
      ALU_OR:  alu_r = aluif_i.PortA | aluif_i.PortB;
      ALU_XOR: alu_r = aluif_i.PortA ^ aluif_i.PortB;
      default: ;
    endcase
  end
  assign aluif_i.OutputPort = alu_r;
  assign aluif_i.Negative   = alu_r[31];
  assign aluif_i.Zero       = (alu_r == '0);
  assign aluif_i.Overflow   = alu_v;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic chk1(input string name, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", name, obs, exp);
    end
  endtask

  task automatic push(input word_t a, input word_t b, input aluop_t op, input logic [3:0] tag);
    bit done = 1'b0;
    req_valid = 1'b1;
    req_opa   = a;
    req_opb   = b;
    req_op    = op;
    req_tag   = tag;
    for (int i = 0; i < 20 && !done; i++) begin
      if (req_ready) done = 1'b1;
      tick();
    end
    req_valid = 1'b0;
    chk1("push_accept", done, 1'b1);
  endtask

  task automatic get_resp(input string name, input word_t res, input logic n, input logic v,
                          input logic z, input logic [3:0] tag);
    bit seen = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (resp_valid) seen = 1'b1;
      else tick();
    end
    chk1({name, "_valid"}, seen, 1'b1);
    chk32({name, "_result"}, resp_result, res);
    chk1({name, "_neg"}, resp_neg, n);
    chk1({name, "_ovf"}, resp_ovf, v);
    chk1({name, "_zero"}, resp_zero, z);
    chk32({name, "_tag"}, 32'(resp_tag), 32'(tag));
    tick();
    resp_ready = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_opa    = '0;
    req_opb    = '0;
    req_op     = '0;
    req_tag    = '0;
    resp_ready = 1'b0;
    tick();
    tick();

    // Reset state
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_resp_valid", resp_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk32("rst_ovf_count", 32'(ovf_count), 32'd0);
    chk32("rst_result", resp_result, 32'd0);
    chk32("rst_tag", 32'(resp_tag), 32'd0);
    chk32("rst_porta", aluif_i.PortA, 32'd0);
    chk32("rst_aluop", 32'(aluif_i.ALUOP), 32'd0);

    // ADD 7,5 accepted on the first edge after reset; check per-cycle latency
    rst       = 1'b0;
    req_valid = 1'b1;
    req_opa   = 32'd7;
    req_opb   = 32'd5;
    req_op    = ALU_ADD;
    req_tag   = 4'd1;
    chk1("lat_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    chk1("lat_k_busy", busy, 1'b1);
    chk1("lat_k_valid", resp_valid, 1'b0);
    chk32("lat_k_porta", aluif_i.PortA, 32'd0);
    tick();
    chk32("lat_k1_porta", aluif_i.PortA, 32'd7);
    chk32("lat_k1_portb", aluif_i.PortB, 32'd5);
    chk32("lat_k1_aluop", 32'(aluif_i.ALUOP), 32'(ALU_ADD));
    chk1("lat_k1_valid", resp_valid, 1'b0);
    tick();
    chk1("lat_k2_valid", resp_valid, 1'b1);
    chk32("lat_k2_result", resp_result, 32'd12);
    chk1("lat_k2_neg", resp_neg, 1'b0);
    chk1("lat_k2_ovf", resp_ovf, 1'b0);
    chk1("lat_k2_zero", resp_zero, 1'b0);
    chk32("lat_k2_tag", 32'(resp_tag), 32'd1);
    chk32("lat_k2_porta", aluif_i.PortA, 32'd0);
    resp_ready = 1'b1;
    tick();
    chk1("lat_done_valid", resp_valid, 1'b0);
    chk1("lat_done_busy", busy, 1'b0);
    resp_ready = 1'b0;

    // SUB to zero, SUB to negative, signed overflow ADD
    push(32'd5, 32'd5, ALU_SUB, 4'd2);
    get_resp("sub_zero", 32'd0, 1'b0, 1'b0, 1'b1, 4'd2);
    push(32'd3, 32'd5, ALU_SUB, 4'd3);
    get_resp("sub_neg", 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 4'd3);
    chk32("ovf_count_before", 32'(ovf_count), 32'd0);
    push(32'h7FFF_FFFF, 32'd1, ALU_ADD, 4'd4);
    get_resp("add_ovf", 32'h8000_0000, 1'b1, 1'b1, 1'b0, 4'd4);
    chk32("ovf_count_after", 32'(ovf_count), 32'd1);

    // Two back-to-back requests with resp_ready held: one response every two cycles
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_opa    = 32'd1;
    req_opb    = 32'd2;
    req_op     = ALU_ADD;
    req_tag    = 4'd5;
    tick();
    req_opa    = 32'd10;
    req_opb    = 32'd4;
    req_op     = ALU_SUB;
    req_tag    = 4'd6;
    tick();
    req_valid  = 1'b0;
    tick();
    chk1("tp_a_valid", resp_valid, 1'b1);
    chk32("tp_a_result", resp_result, 32'd3);
    chk32("tp_a_tag", 32'(resp_tag), 32'd5);
    tick();
    chk1("tp_gap_valid", resp_valid, 1'b0);
    tick();
    chk1("tp_b_valid", resp_valid, 1'b1);
    chk32("tp_b_result", resp_result, 32'd6);
    chk32("tp_b_tag", 32'(resp_tag), 32'd6);
    tick();
    chk1("tp_end_valid", resp_valid, 1'b0);
    chk1("tp_end_busy", busy, 1'b0);
    resp_ready = 1'b0;

    // Stalled response: tags 0..4 back-to-back fill the queue behind tag 0
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_opa   = 32'd100;
      req_opb   = 32'(i);
      req_op    = ALU_ADD;
      req_tag   = 4'(i);
      chk1($sformatf("fill_ready%0d", i), req_ready, 1'b1);
      tick();
    end
    req_valid = 1'b0;
    chk1("full_ready", req_ready, 1'b0);
    chk1("full_busy", busy, 1'b1);
    chk1("full_resp_valid", resp_valid, 1'b1);
    chk32("full_resp_tag", 32'(resp_tag), 32'd0);
    req_valid = 1'b1;
    req_opb   = 32'd5;
    req_tag   = 4'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("held_ready", req_ready, 1'b0);
    end
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      get_resp($sformatf("order%0d", i), 32'(100 + i), 1'b0, 1'b0, 1'b0, 4'(i));
    end
    resp_ready = 1'b1;
    tick();
    tick();
    chk1("order_end_valid", resp_valid, 1'b0);
    chk1("order_end_busy", busy, 1'b0);
    resp_ready = 1'b0;

    // Reset while in DRIVE with two entries queued
    req_valid = 1'b1;
    req_opa   = 32'h7FFF_FFFF;
    req_opb   = 32'd1;
    req_op    = ALU_ADD;
    req_tag   = 4'd10;
    tick();
    req_opa   = 32'd1;
    req_opb   = 32'd1;
    req_tag   = 4'd11;
    tick();
    req_valid = 1'b0;
    chk32("pre_rst_porta", aluif_i.PortA, 32'h7FFF_FFFF);
    rst = 1'b1;
    #1;
    chk1("mid_rst_valid", resp_valid, 1'b0);
    chk1("mid_rst_ready", req_ready, 1'b1);
    chk1("mid_rst_busy", busy, 1'b0);
    chk32("mid_rst_porta", aluif_i.PortA, 32'd0);
    chk32("mid_rst_ovf_count", 32'(ovf_count), 32'd0);
    tick();
    rst        = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("post_rst_no_resp", resp_valid, 1'b0);
    end
    chk1("post_rst_busy", busy, 1'b0);
    resp_ready = 1'b0;

    // Normal operation resumes after the mid-flight reset
    push(32'h0000_F0F0, 32'h0000_FF00, ALU_XOR, 4'd9);
    get_resp("xor", 32'h0000_0FF0, 1'b0, 1'b0, 1'b0, 4'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
